// File: rtl/aes_decrypt.sv
// aes_decrypt: iterative AES-128 inverse cipher, one round per clock.
//
// The round key is expanded on the fly. The schedule first runs forward from the
// cipher key to rk10. During the rounds it then runs backwards, so only one round
// key register is ever held.
//
// Optional feature (macro AES_DEC_KEY_CACHE_EN): a cache holds the last cipher key
// and its rk10. When the same key is accepted again, the forward expansion is
// skipped and the latency drops from 21 to 11 cycles.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   ciphertext 128-bit block; bits [127:120] are byte 0
//   key        128-bit cipher key, same byte order
//   in_valid   request, taken only while in_ready is high
//   in_ready   core idle and able to accept
//   plaintext  registered result; holds until the next completion or reset
//   out_valid  one-cycle pulse marking a new plaintext
module aes_decrypt #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] plaintext,
  output logic         out_valid
);

  if (NR != 10) begin : g_nr_check
    $error("aes_decrypt supports only NR = 10");
  end

  typedef logic [0:15][7:0] blk_t;
  typedef enum logic [1:0] {IDLE, KEXP, INIT, ROUND} fsm_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [0:255][7:0] ISBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by one of the InvMixColumns constants 09/0b/0d/0e.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    case (c)
      4'h9:    return x8 ^ a;
      4'hb:    return x8 ^ x2 ^ a;
      4'hd:    return x8 ^ x4 ^ a;
      default: return x8 ^ x4 ^ x2;
    endcase
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1: return 8'h01;  4'd2: return 8'h02;  4'd3: return 8'h04;
      4'd4: return 8'h08;  4'd5: return 8'h10;  4'd6: return 8'h20;
      4'd7: return 8'h40;  4'd8: return 8'h80;  4'd9: return 8'h1b;
      4'd10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // rk_{i-1} -> rk_i, with rc = rcon(i)
  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // rk_i -> rk_{i-1}, with rc = rcon(i); the last word must be recovered first
  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] p0, p1, p2, p3;
    p3 = k[31:0] ^ k[63:32];
    p2 = k[63:32] ^ k[95:64];
    p1 = k[95:64] ^ k[127:96];
    p0 = k[127:96] ^ sub_rot(p3) ^ {rc, 24'h0};
    return {p0, p1, p2, p3};
  endfunction

  // Bytes are column-major: byte index = 4*column + row; row r rotates right by r.
  function automatic blk_t inv_shift_sub(input blk_t s);
    blk_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[4'(4*c + r)] = ISBOX[s[4'(4*((c + 4 - r) % 4) + r)]];
    return o;
  endfunction

  function automatic blk_t inv_mix(input blk_t s);
    blk_t o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[4'(4*c)];
      a1 = s[4'(4*c + 1)];
      a2 = s[4'(4*c + 2)];
      a3 = s[4'(4*c + 3)];
      o[4'(4*c)]     = gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9);
      o[4'(4*c + 1)] = gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd);
      o[4'(4*c + 2)] = gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb);
      o[4'(4*c + 3)] = gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he);
    end
    return o;
  endfunction

  fsm_t         fsm_q, fsm_d;
  blk_t         blk_p0;
  logic [127:0] rk_p0;
  logic [3:0]   rnd_p0;
  blk_t         rnd_res;
  logic         hit;
  logic [127:0] rk_hit;

  assign rnd_res = (rnd_p0 == 4'd0) ? blk_t'(inv_shift_sub(blk_p0) ^ rk_p0)
                                    : inv_mix(inv_shift_sub(blk_p0) ^ rk_p0);

`ifdef AES_DEC_KEY_CACHE_EN
  logic         cache_vld;
  logic [127:0] cache_key, cache_rk10;

  assign hit    = cache_vld && (key == cache_key);
  assign rk_hit = cache_rk10;

  // The key is captured at accept; its rk10 becomes known, and the entry valid, at INIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_vld  <= 1'b0;
      cache_key  <= '0;
      cache_rk10 <= '0;
    end else if (fsm_q == IDLE && in_valid && !hit) begin
      cache_vld <= 1'b0;
      cache_key <= key;
    end else if (fsm_q == INIT) begin
      cache_vld  <= 1'b1;
      cache_rk10 <= rk_p0;
    end
  end
`else
  assign hit    = 1'b0;
  assign rk_hit = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) fsm_q <= IDLE;
    else     fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (in_valid) fsm_d = hit ? INIT : KEXP;
      KEXP:    if (rnd_p0 == 4'd10) fsm_d = INIT;
      INIT:    fsm_d = ROUND;
      default: if (rnd_p0 == 4'd0) fsm_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (fsm_q == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_p0    <= '0;
      rk_p0     <= '0;
      rnd_p0    <= '0;
      plaintext <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (fsm_q)
        // accept: on a cache hit the key register is loaded with rk10 directly
        IDLE: if (in_valid) begin
          blk_p0 <= ciphertext;
          rk_p0  <= hit ? rk_hit : key;
          rnd_p0 <= 4'd1;
        end
        // forward schedule: rnd_p0 names the round key being produced
        KEXP: begin
          rk_p0  <= key_fwd(rk_p0, rcon(rnd_p0));
          rnd_p0 <= rnd_p0 + 4'd1;
        end
        // initial AddRoundKey with rk10, then start walking the schedule back
        INIT: begin
          blk_p0 <= blk_p0 ^ rk_p0;
          rk_p0  <= key_inv(rk_p0, rcon(4'd10));
          rnd_p0 <= 4'd9;
        end
        // inverse rounds 9..0: rk_p0 holds rk_r while rnd_p0 = r
        default: begin
          blk_p0 <= rnd_res;
          if (rnd_p0 != 4'd0) begin
            rk_p0  <= key_inv(rk_p0, rcon(rnd_p0));
            rnd_p0 <= rnd_p0 - 4'd1;
          end else begin
            plaintext <= rnd_res;
            out_valid <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
